// File: rtl/dsp_cic_pkg.sv
// Shared definitions for the CIC decimator/interpolator family.
//   cic_bout()   : full-precision register width for a CIC cascade
//   clamp_rate() : maps a requested runtime rate into 1..rmax
//   CUT_ROUND / CUT_TRUNC : legal values of the CUT_METHOD parameter
package dsp_cic_pkg;

  localparam string CUT_ROUND = "ROUND";
  localparam string CUT_TRUNC = "CUT";

  // Worst-case growth of an N-stage CIC is N*log2(R*M) bits over the input.
  function automatic int cic_bout(input int bin, input int n, input int rmax, input int m);
    return bin + n * $clog2(rmax * m);
  endfunction

  // Rates 0 and 1 both mean "no decimation"; anything above rmax saturates.
  function automatic int unsigned clamp_rate(input int unsigned rate, input int unsigned rmax);
    if (rate <= 1) return 1;
    if (rate > rmax) return rmax;
    return rate;
  endfunction

endpackage

// File: rtl/dsp_round_sat.sv
// Reduces a BOUT-bit two's complement value to its top COUT bits, rounding
// to nearest with ties away from zero and saturating positive overflow.
//   din  : BOUT-bit full-precision input
//   dout : COUT-bit rounded/saturated result
module dsp_round_sat #(
  parameter int BOUT = 34,
  parameter int COUT = 16
) (
  input  logic [BOUT-1:0] din,
  output logic [COUT-1:0] dout
);

  generate
    if (BOUT > COUT) begin : g_round
      localparam int FW = BOUT - COUT;
      localparam logic [COUT-1:0] POS_MAX = {1'b0, {(COUT-1){1'b1}}};

      logic [COUT-1:0] top;
      logic [FW-1:0]   frac_rest;
      logic            rnd_up;

      always_comb begin
        top       = din[BOUT-1 -: COUT];
        frac_rest = din[FW-1:0];
        frac_rest[FW-1] = 1'b0;
        // Exactly one half on a negative value must not move toward zero.
        rnd_up    = din[FW-1] && (!din[BOUT-1] || (|frac_rest));
        if (rnd_up && (top == POS_MAX)) begin
          dout = POS_MAX;
        end else begin
          dout = top + {{(COUT-1){1'b0}}, rnd_up};
        end
      end
    end else begin : g_pass
      assign dout = COUT'($signed(din));
    end
  endgenerate

endmodule

// File: rtl/dsp_cic_dec_tdm.sv
// Time-multiplexed CIC decimator: CH channels share one N-stage integrator /
// comb datapath; per-channel state lives in register arrays indexed by din_ch.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : BIN-bit signed sample, qualified by din_vld, channel din_ch
//   rate       : runtime decimation rate, latched (clamped) on rate_ld pulse,
//                which also clears all channel state
//   dout       : BOUT-bit full-precision result, dout_cut its COUT-bit scaled
//                form; dout_vld pulses one cycle, dout_ch names the channel
module dsp_cic_dec_tdm
  import dsp_cic_pkg::*;
#(
  parameter int    CH         = 4,
  parameter int    N          = 5,
  parameter int    M          = 1,
  parameter int    RMAX       = 64,
  parameter int    BIN        = 16,
  parameter int    COUT       = 16,
  parameter string CUT_METHOD = "ROUND",
  localparam int   BOUT       = cic_bout(BIN, N, RMAX, M),
  localparam int   CHW        = (CH > 1) ? $clog2(CH) : 1,
  localparam int   RW         = $clog2(RMAX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BIN-1:0]  din,
  input  logic            din_vld,
  input  logic [CHW-1:0]  din_ch,
  input  logic [RW-1:0]   rate,
  input  logic            rate_ld,
  output logic [BOUT-1:0] dout,
  output logic [COUT-1:0] dout_cut,
  output logic            dout_vld,
  output logic [CHW-1:0]  dout_ch
);

  logic [BOUT-1:0] integ_q    [CH][N];
  logic [BOUT-1:0] integ_d    [CH][N];
  logic [BOUT-1:0] comb_dly_q [CH][N][M];
  logic [BOUT-1:0] comb_dly_d [CH][N][M];
  logic [RW-1:0]   cnt_q      [CH];
  logic [RW-1:0]   cnt_d      [CH];
  logic [RW-1:0]   reff_q,     reff_d;
  logic [BOUT-1:0] dout_q,     dout_d;
  logic            dout_vld_q, dout_vld_d;
  logic [CHW-1:0]  dout_ch_q,  dout_ch_d;
  logic            ch_ok;

  // Channel indices past CH can only occur when CH is not a power of two.
  generate
    if (CH == (1 << CHW)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      localparam logic [CHW:0] CH_LIM = (CHW+1)'(CH);
      assign ch_ok = ({1'b0, din_ch} < CH_LIM);
    end
  endgenerate

  always_comb begin
    logic [BOUT-1:0] acc;
    logic [BOUT-1:0] prev;
    integ_d    = integ_q;
    comb_dly_d = comb_dly_q;
    cnt_d      = cnt_q;
    reff_d     = reff_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    dout_ch_d  = dout_ch_q;
    acc        = '0;
    prev       = '0;

    if (rate_ld) begin
      reff_d = RW'(clamp_rate(32'(rate), 32'(RMAX)));
      for (int unsigned c = 0; c < CH; c++) begin
        cnt_d[c] = '0;
        for (int unsigned k = 0; k < N; k++) begin
          integ_d[c][k] = '0;
          for (int unsigned j = 0; j < M; j++) begin
            comb_dly_d[c][k][j] = '0;
          end
        end
      end
    end else if (din_vld && ch_ok) begin
      // Each stage adds the freshly updated sum of the stage before it.
      acc = BOUT'($signed(din));
      for (int unsigned k = 0; k < N; k++) begin
        acc              = acc + integ_q[din_ch][k];
        integ_d[din_ch][k] = acc;
      end

      if (cnt_q[din_ch] == reff_q - 1'b1) begin
        cnt_d[din_ch] = '0;
        // Each comb stage subtracts its input from M decimated samples ago.
        for (int unsigned k = 0; k < N; k++) begin
          prev = comb_dly_q[din_ch][k][M-1];
          for (int unsigned j = M - 1; j > 0; j--) begin
            comb_dly_d[din_ch][k][j] = comb_dly_q[din_ch][k][j-1];
          end
          comb_dly_d[din_ch][k][0] = acc;
          acc = acc - prev;
        end
        dout_d     = acc;
        dout_vld_d = 1'b1;
        dout_ch_d  = din_ch;
      end else begin
        cnt_d[din_ch] = cnt_q[din_ch] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
        for (int unsigned k = 0; k < N; k++) begin
          integ_q[c][k] <= '0;
          for (int unsigned j = 0; j < M; j++) begin
            comb_dly_q[c][k][j] <= '0;
          end
        end
      end
      reff_q     <= RW'(RMAX);
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_ch_q  <= '0;
    end else begin
      integ_q    <= integ_d;
      comb_dly_q <= comb_dly_d;
      cnt_q      <= cnt_d;
      reff_q     <= reff_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_ch_q  <= dout_ch_d;
    end
  end

  // Scaling is fixed to the RMAX gain, so dout_cut always takes the top bits.
  generate
    if (CUT_METHOD == CUT_ROUND) begin : g_round
      dsp_round_sat #(
        .BOUT(BOUT),
        .COUT(COUT)
      ) u_round_sat (
        .din (dout_q),
        .dout(dout_cut)
      );
    end else begin : g_cut
      assign dout_cut = dout_q[BOUT-1 -: COUT];
    end
  endgenerate

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_ch  = dout_ch_q;

endmodule

// File: tb/tb_dsp_cic_dec_tdm.sv
module tb_dsp_cic_dec_tdm;

  localparam int BOUT = 34;  // 16 + 3*log2(64)

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     din;
  logic            din_vld;
  logic [1:0]      din_ch;
  logic [6:0]      rate;
  logic            rate_ld;

  logic [BOUT-1:0] dout_r, dout_c, dout_3;
  logic [15:0]     cut_r, cut_c, cut_3;
  logic            vld_r, vld_c, vld_3;
  logic            ch_r, ch_c;
  logic [1:0]      ch_3;

  always #5 clk = ~clk;

  dsp_cic_dec_tdm #(
    .CH(2), .N(3), .M(1), .RMAX(64), .BIN(16), .COUT(16), .CUT_METHOD("ROUND")
  ) u_dut_rnd (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_ch(din_ch[0:0]),
    .rate(rate), .rate_ld(rate_ld), .dout(dout_r), .dout_cut(cut_r),
    .dout_vld(vld_r), .dout_ch(ch_r)
  );

  dsp_cic_dec_tdm #(
    .CH(2), .N(3), .M(1), .RMAX(64), .BIN(16), .COUT(16), .CUT_METHOD("CUT")
  ) u_dut_cut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_ch(din_ch[0:0]),
    .rate(rate), .rate_ld(rate_ld), .dout(dout_c), .dout_cut(cut_c),
    .dout_vld(vld_c), .dout_ch(ch_c)
  );

  // Three channels on a 2-bit index, so din_ch=3 is an illegal slot.
  dsp_cic_dec_tdm #(
    .CH(3), .N(3), .M(1), .RMAX(64), .BIN(16), .COUT(16), .CUT_METHOD("ROUND")
  ) u_dut_ch3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_ch(din_ch),
    .rate(rate), .rate_ld(rate_ld), .dout(dout_3), .dout_cut(cut_3),
    .dout_vld(vld_3), .dout_ch(ch_3)
  );

  typedef struct {
    int     rate;
    int     reff;
    int     x;
    longint exp_dout;
    longint exp_rnd;
    longint exp_cut;
  } vec_t;

  vec_t   tbl [13];
  int     vecs = 0;
  int     miss = 0;
  longint dc_exp [4] = '{12000, 45600, 51200, 51200};
  longint iso_exp[3] = '{20000, 60000, 64000};
  longint rc_exp [3] = '{2000, 6000, 6400};
  int     pv     [5] = '{5, -7, 300, 32767, -32768};

  function automatic longint s34(input logic [BOUT-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    vecs++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] c, input int x);
    din_vld = v;
    din_ch  = c;
    din     = 16'(x);
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  task automatic flush(input int r);
    rate    = 7'(r);
    rate_ld = 1'b1;
    @(posedge clk);
    #1;
    rate_ld = 1'b0;
    chk("flush_no_vld", longint'(vld_r), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int bad, ch1_outs, n, c, last_ch;

    // {rate, Reff, DC input, dout, ROUND dout_cut, CUT dout_cut} after 3*Reff samples.
    // Output scale is fixed at 2^18 (RMAX gain), so dout_cut = dout / 2^18.
    tbl[0]  = '{8,   8,  100,    51200,            0,      0};
    tbl[1]  = '{8,   8,  32767,  16776704,         64,     63};
    tbl[2]  = '{8,   8,  256,    131072,           1,      0};
    tbl[3]  = '{8,   8,  -256,   -131072,          -1,     -1};
    tbl[4]  = '{8,   8,  -255,   -130560,          0,      -1};
    tbl[5]  = '{8,   8,  -257,   -131584,          -1,     -1};
    tbl[6]  = '{2,   2,  -500,   -4000,            0,      -1};
    tbl[7]  = '{0,   1,  1234,   1234,             0,      0};
    tbl[8]  = '{1,   1,  -3,     -3,               0,      -1};
    // 200 does not fit the 7-bit rate port; the 72 it truncates to still clamps to 64.
    tbl[9]  = '{200, 64, 32767,  64'sd8589672448,  32767,  32767};
    tbl[10] = '{100, 64, -32768, -64'sd8589934592, -32768, -32768};
    tbl[11] = '{4,   4,  1000,   64000,            0,      0};
    tbl[12] = '{64,  64, 16384,  64'sd4294967296,  16384,  16384};

    rst_n = 1'b0; din = '0; din_vld = 1'b0; din_ch = '0; rate = '0; rate_ld = 1'b0;

    // Reset state, then Reff defaults to RMAX without any rate load.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", s34(dout_r), 0);
    chk("rst_cut", s16(cut_r), 0);
    chk("rst_vld", longint'(vld_r), 0);
    chk("rst_ch", longint'(ch_r), 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 2'd1, 1);
      if (vld_r !== (i == 64)) bad++;
    end
    chk("rst_reff_vld_pattern", bad, 0);
    chk("rst_reff_dout", s34(dout_r), 45760);
    chk("rst_reff_ch", longint'(ch_r), 1);

    // DC gain at rate 8 on ch0 only.
    flush(8);
    bad = 0; ch1_outs = 0;
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 2'd0, 100);
      if (vld_r !== ((i % 8) == 0)) bad++;
      if (vld_r && ch_r) ch1_outs++;
      if (vld_r && ((i % 8) == 0)) begin
        chk("dc_dout", s34(dout_r), dc_exp[i/8-1]);
        chk("dc_ch", longint'(ch_r), 0);
      end
    end
    chk("dc_vld_pattern", bad, 0);
    chk("dc_ch1_silent", ch1_outs, 0);

    // Channel isolation: interleaved +1000 / -1000 at rate 4.
    flush(4);
    bad = 0; last_ch = -1;
    for (int i = 0; i < 24; i++) begin
      c = i % 2;
      n = i / 2 + 1;
      step(1'b1, 2'(c), (c == 0) ? 1000 : -1000);
      if (vld_r !== ((n % 4) == 0)) bad++;
      if (vld_r && ((n % 4) == 0)) begin
        chk("iso_dout", s34(dout_r), (c == 0) ? iso_exp[n/4-1] : -iso_exp[n/4-1]);
        chk("iso_ch", longint'(ch_r), c);
        if (last_ch >= 0) chk("iso_ch_alternates", longint'(ch_r != last_ch[0]), 1);
        last_ch = int'(ch_r);
      end
    end
    chk("iso_vld_pattern", bad, 0);

    // Rate change mid-stream: the load cycle coincides with a would-be event.
    flush(8);
    for (int i = 0; i < 7; i++) step(1'b1, 2'd0, 100);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 100);
    rate = 7'd4; rate_ld = 1'b1; din_vld = 1'b1; din_ch = 2'd0; din = 16'd100;
    @(posedge clk);
    #1;
    rate_ld = 1'b0; din_vld = 1'b0;
    chk("rc_suppress_vld", longint'(vld_r), 0);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      c = i % 2;
      n = i / 2 + 1;
      step(1'b1, 2'(c), 100);
      if (vld_r !== ((n % 4) == 0)) bad++;
      if (vld_r && ((n % 4) == 0)) begin
        chk("rc_dout", s34(dout_r), rc_exp[n/4-1]);
        chk("rc_ch", longint'(ch_r), c);
      end
    end
    chk("rc_vld_pattern", bad, 0);

    // Rate 0 clamps to 1: every sample comes straight through.
    flush(0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd1, pv[i]);
      chk("r0_vld", longint'(vld_r), 1);
      chk("r0_dout", s34(dout_r), pv[i]);
      chk("r0_ch", longint'(ch_r), 1);
    end
    // Illegal channel on the 3-channel instance.
    step(1'b1, 2'd0, 55);
    chk("ill_pre_vld", longint'(vld_3), 1);
    chk("ill_pre_dout", s34(dout_3), 55);
    step(1'b1, 2'd3, 999);
    chk("ill_vld", longint'(vld_3), 0);
    chk("ill_dout_held", s34(dout_3), 55);
    chk("ill_ch_held", longint'(ch_3), 0);
    chk("ill_cut_held", s16(cut_3), 0);
    step(1'b1, 2'd2, -9);
    chk("ill_ch2_dout", s34(dout_3), -9);
    chk("ill_ch2_ch", longint'(ch_3), 2);
    step(1'b1, 2'd0, 77);
    chk("ill_post_dout", s34(dout_3), 77);

    // Reset mid-frame with ch0 counter at 5.
    flush(8);
    for (int i = 0; i < 13; i++) step(1'b1, 2'd0, 100);
    chk("mid_pre_dout", s34(dout_r), 12000);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_dout", s34(dout_r), 0);
    chk("mid_rst_cut", s16(cut_r), 0);
    chk("mid_rst_vld", longint'(vld_r), 0);
    chk("mid_rst_ch", longint'(ch_r), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 2'd0, 0);
    chk("mid_post_no_vld", longint'(vld_r), 0);
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 2'd0, 100);
      if (vld_r !== (i == 64)) bad++;
    end
    chk("mid_post_vld_pattern", bad, 0);
    chk("mid_post_dout", s34(dout_r), 4576000);

    // Table: DC response, clamping and output scaling in both modes.
    for (int t = 0; t < 13; t++) begin
      flush(tbl[t].rate);
      bad = 0;
      for (int i = 1; i <= 3 * tbl[t].reff; i++) begin
        step(1'b1, 2'd0, tbl[t].x);
        if (vld_r !== ((i % tbl[t].reff) == 0)) bad++;
      end
      chk($sformatf("tbl%0d_vld_pattern", t), bad, 0);
      chk($sformatf("tbl%0d_vld_cut", t), longint'(vld_c), 1);
      chk($sformatf("tbl%0d_dout", t), s34(dout_r), tbl[t].exp_dout);
      chk($sformatf("tbl%0d_dout_cutmode", t), s34(dout_c), tbl[t].exp_dout);
      chk($sformatf("tbl%0d_round", t), s16(cut_r), tbl[t].exp_rnd);
      chk($sformatf("tbl%0d_cut", t), s16(cut_c), tbl[t].exp_cut);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/dsp_cic_dec_tdm.md
DSP_CIC_DEC_TDM -- requirements
Module: dsp_cic_dec_tdm

Interface
REQ-001 SHALL have parameter CH, default 4: number of time-multiplexed channels (1..16).
REQ-002 SHALL have parameter N, default 5: integrator and comb stage count.
REQ-003 SHALL have parameter M, default 1: differential delay, legal values 1 or 2.
REQ-004 SHALL have parameter RMAX, default 64: maximum runtime decimation rate.
REQ-005 SHALL have parameter BIN, default 16: input width, two's complement.
REQ-006 SHALL have parameter COUT, default 16: width of the clipped output.
REQ-007 SHALL have parameter CUT_METHOD, default "ROUND": "ROUND" or "CUT".
REQ-008 SHALL have derived localparam BOUT = BIN + N*$clog2(RMAX*M), with CHW = max(1,$clog2(CH)) and RW = $clog2(RMAX+1).
REQ-009 clk  in  1  clock; all state is updated on the rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 din  in  BIN  input sample.
REQ-012 din_vld  in  1  sample strobe.
REQ-013 din_ch  in  CHW  channel index of din.
REQ-014 rate  in  RW  decimation rate R.
REQ-015 rate_ld  in  1  one-cycle pulse: load rate and flush.
REQ-016 dout  out  BOUT  full-precision output.
REQ-017 dout_cut  out  COUT  scaled output (rounded or cut).
REQ-018 dout_vld  out  1  one-cycle output strobe.
REQ-019 dout_ch  out  CHW  channel index of dout.

Function
REQ-020 Each channel SHALL own independent integrator, decimation-counter and comb state.
- Only the din_ch slot is touched on an accepted sample.
REQ-021 Accepted sample (din_vld=1, din_ch<CH, rate_ld=0): the block SHALL update that channel's N-stage integrator cascade.
- Same chained-sum form per stage as the single-channel decimator.
- Input is sign-extended to BOUT.
- Arithmetic is modulo 2^BOUT, with wrap-around permitted.
REQ-022 A sample with din_ch>=CH SHALL be ignored, with no state change.
REQ-023 The per-channel counter cnt[ch] SHALL count accepted samples from 0 to Reff-1, then wrap to 0.
REQ-024 The decimation event is an accepted sample with cnt[ch]==Reff-1. On it, the block SHALL pass the new last-integrator sum through the channel's N comb stages.
- Comb delay is M decimated samples.
- The comb result is registered.
REQ-025 Output latency SHALL be exactly 1 clk after the decimation event.
- dout_vld pulses for 1 cycle.
- dout_ch equals the event channel.
- dout and dout_cut hold their values until the next event.
REQ-026 Reff SHALL be the loaded rate clamped: 0 or 1 becomes 1, and values above RMAX become RMAX.
- With Reff=1, every accepted sample produces an output.
REQ-027 rate_ld=1 SHALL flush the block:
- Latch Reff.
- Zero every channel's integrators, combs and counters.
- Suppress any dout_vld in the next cycle.
- A din_vld in the same cycle is dropped.
REQ-028 CUT mode SHALL produce dout_cut = dout[BOUT-1:BOUT-COUT].
REQ-029 ROUND mode SHALL round dout[BOUT-1:BOUT-COUT] to nearest, with ties away from zero.
- Positive overflow SHALL saturate to 2^(COUT-1)-1.
REQ-030 Gain is (Reff*M)^N, with no runtime rescaling: dout_cut scaling is fixed to RMAX.

Reset
REQ-031 While rst_n=0, the block SHALL hold all integrators, combs, counters, dout, dout_cut, dout_vld and dout_ch at 0, and Reff at RMAX.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight state immediately, and no dout_vld SHALL occur in the cycle after release.

Structure
REQ-033 A shared package dsp_cic_pkg SHALL hold:
- the BOUT width function;
- the CUT_METHOD string constants;
- the clamp-rate function.
REQ-034 Per-channel state SHALL be stored as register arrays indexed by channel, not by replicating the datapath per channel.
REQ-035 Rounding and saturation SHALL live in the sub-module dsp_round_sat (parameters BOUT and COUT), which is reusable by the interpolator.

Verification
REQ-036 The bench SHALL cover the following scenarios, with CH=2, N=3, M=1, RMAX=64, BIN=16.
- DC gain: rate=8; ch0 receives constant 100 -> from the 3rd output on, dout=51200; ch1 stays silent with no dout_ch=1 output.
- Channel isolation: interleave ch0=+1000 and ch1=-1000 at rate 4 -> steady state gives ch0 dout=64000 and ch1 dout=-64000, with dout_ch alternating.
- Rate change: switch rate_ld from 8 to 4 mid-stream -> no dout_vld in the next cycle; the first output follows 4 accepted samples per channel; DC 100 settles to 6400.
- Clamp and illegal inputs: rate=0 gives an output per sample; rate=200 behaves as 64; din_ch=3 leaves the outputs unchanged.
- Rounding: full-scale positive DC at rate 64 in ROUND mode -> dout_cut=32767, with no wrap to negative; in CUT mode the result equals the top bits.
- Reset mid-frame: assert rst_n low with cnt=5 -> all outputs are 0; after release, the first output requires a full Reff samples.
